// File: rtl/bash_round_const_gen.sv
// bash_round_const_gen
// Round-constant sequencer for the Bash-f permutation core. A start request
// in IDLE loads the seed (INIT, or seed_i when seed_en_i is high). The block
// then presents one constant per round over a valid/ready handshake. Each
// accepted beat advances the constant by STEPS LFSR steps in a single cycle.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start_i           - start request (IDLE only)
//   seed_en_i, seed_i - optional caller seed, port byte order
//   const_o           - registered constant, port byte order
//   const_valid_o     - const_o valid (high in RUN)
//   const_ready_i     - consumer accepts the presented beat
//   round_o           - index of the presented beat
//   last_o            - presented beat is round ROUNDS-1
//   busy_o            - high in RUN
//   done_o            - one-cycle pulse after the final beat is accepted
module bash_round_const_gen #(
    parameter int unsigned W         = 64,
    parameter logic [W-1:0] POLY     = 64'hAED8E07F99E12BDC,
    parameter logic [W-1:0] INIT     = 64'hB194BAC80A08F53B,
    parameter int unsigned ROUNDS    = 24,
    parameter int unsigned STEPS     = 1,
    parameter bit          BYTE_SWAP = 1'b1,
    localparam int unsigned RW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          seed_en_i,
    input  logic [W-1:0]  seed_i,
    output logic [W-1:0]  const_o,
    output logic          const_valid_o,
    input  logic          const_ready_i,
    output logic [RW-1:0] round_o,
    output logic          last_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  const_q, const_d;
    logic [RW-1:0] round_q, round_d;
    logic          done_q,  done_d;
    logic [W-1:0]  adv;

    // Maps between port byte order and the arithmetic domain (self-inverse).
    function automatic logic [W-1:0] bs(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
        if (BYTE_SWAP) begin
            for (int unsigned i = 0; i < W / 8; i++) begin
                r[8*i +: 8] = x[W-8-8*i +: 8];
            end
        end
        return r;
    endfunction

    // One LFSR step: shift in the arithmetic domain, feedback XOR in port order.
    function automatic logic [W-1:0] step(input logic [W-1:0] s);
        logic [W-1:0] n;
        n = bs(s);
        return bs(n >> 1) ^ (n[0] ? POLY : '0);
    endfunction

    always_comb begin
        adv = const_q;
        for (int unsigned i = 0; i < STEPS; i++) begin
            adv = step(adv);
        end
    end

    always_comb begin
        state_d = state_q;
        const_d = const_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    const_d = seed_en_i ? seed_i : INIT;
                    round_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (const_ready_i) begin
                    if (round_q == LAST_ROUND) begin
                        // Final beat: constant and round index hold for inspection.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        const_d = adv;
                        round_d = round_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            const_q <= INIT;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            const_q <= const_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign const_o       = const_q;
    assign const_valid_o = (state_q == RUN);
    assign busy_o        = (state_q == RUN);
    assign round_o       = round_q;
    assign last_o        = (state_q == RUN) && (round_q == LAST_ROUND);
    assign done_o        = done_q;

endmodule

// File: doc/bash_round_const_gen.md
# bash_round_const_gen

Parametrised round-constant sequencer for the Bash-f permutation core. On a start request it loads a seed (the default Bash-f initial constant or a caller-supplied word) and emits one constant per round over a valid/ready handshake. Each emitted constant is advanced by `STEPS` LFSR steps in a single cycle. It replaces the single-step, free-running constant stage with a counted, flow-controlled source. The permutation round controller instantiates it and consumes one constant per round.

## Interface
- `W`, 64: constant width in bits; multiple of 8.
- `POLY`, 64'hAED8E07F99E12BDC: feedback word, in port byte order.
- `INIT`, 64'hB194BAC80A08F53B: default seed, in port byte order.
- `ROUNDS`, 24: constants emitted per run; must be at least 1.
- `STEPS`, 1: LFSR steps applied per accepted beat; range 1..4.
- `BYTE_SWAP`, 1: 1 means port words are byte-reversed relative to the arithmetic domain; 0 means no swap.

- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start_i`, in, 1: start request; sampled only in IDLE.
- `seed_en_i`, in, 1: when high together with an accepted start, load `seed_i` instead of `INIT`.
- `seed_i`, in, W: caller seed, in port order.
- `const_o`, out, W: current constant, in port order; registered.
- `const_valid_o`, out, 1: `const_o` is valid.
- `const_ready_i`, in, 1: consumer accepts the beat.
- `round_o`, out, max(1,$clog2(ROUNDS)): index of the beat currently presented.
- `last_o`, out, 1: high while the presented beat is round `ROUNDS-1`.
- `busy_o`, out, 1: high in RUN.
- `done_o`, out, 1: one-cycle pulse after the final beat is accepted.

## Operation
- Step function on port-order word s:
  - n = bs(s), where bs is a byte reversal when `BYTE_SWAP`=1 and the identity otherwise.
  - s' = bs(n >> 1) XOR (n[0] ? `POLY` : 0).
  - The shift is logical: a zero enters the MSB of n.
- Advance = `STEPS` chained step functions, fully combinational, with a single register stage (`const_o` is the state register).
- States:
  - IDLE: `const_valid_o`=0, `busy_o`=0.
    - `start_i`=1 → load the state register with `seed_en_i` ? `seed_i` : `INIT`; set `round_o`=0; go to RUN.
  - RUN: `const_valid_o`=1, `busy_o`=1.
    - Handshake = `const_valid_o` & `const_ready_i`.
    - Handshake with `round_o` < `ROUNDS-1` → state ← advance(state), `round_o`+1, stay in RUN.
    - Handshake with `round_o` = `ROUNDS-1` → go to IDLE; `done_o`=1 for the next cycle; the state register and `round_o` hold their values.
- `start_i` in RUN is ignored, including in the cycle of the final handshake.
- `start_i` in the cycle `done_o` is high is accepted, because that cycle is in IDLE.
- No handshake in RUN → `const_o`, `round_o` and `last_o` hold stable.
- An all-zero seed is a fixed point; the block emits zeros with no special handling.

## Timing
- Reset values (applied asynchronously, immediately on `rst`):
  - state register = `INIT`, so `const_o` = `INIT`.
  - `round_o`=0, `const_valid_o`=0, `busy_o`=0, `last_o`=0, `done_o`=0.
  - FSM = IDLE.
- Latency from start to first beat: `start_i` sampled at edge k → `const_valid_o`=1 with the seed on `const_o` after edge k.
- Throughput: one beat per cycle while `const_ready_i`=1.
  - Minimum run: `ROUNDS` cycles of RUN plus one `done_o` cycle.
  - Back-to-back runs leave no gap beyond the `done_o` cycle.
- `done_o` is registered and high exactly one cycle after the edge that accepted the final beat.
- Reset asserted mid-run aborts the run. No `done_o` is produced. After `rst` deasserts, the block waits in IDLE for `start_i`.

## Test plan
- Single step:
  - Stimulus: `BYTE_SWAP`=1, `STEPS`=1, seed 64'h0200000000000000, ready held high.
  - Required beats: 64'h0200000000000000, then 64'h0100000000000000, then 64'hAED8E07F99E12BDC.
- Multi-step:
  - Stimulus: same seed with `STEPS`=2.
  - Required beats: 64'h0200000000000000, then 64'hAED8E07F99E12BDC.
  - The full 24-beat sequence matches a software model applied `STEPS` times per beat.
- Backpressure:
  - Stimulus: in round 3, drop `const_ready_i` for 5 cycles.
  - Required: `const_o`, `round_o`=3 and `const_valid_o`=1 stay constant; the sequence resumes unchanged when ready returns.
- Full run:
  - Stimulus: `ROUNDS`=24, default seed, ready held high.
  - Required: exactly 24 beats; `last_o` high only on beat 23; `done_o` pulses one cycle afterwards; `busy_o` falls in that same cycle.
  - A `start_i` pulse during beats 5 to 23 has no effect.
- Restart on done:
  - Stimulus: pulse `start_i` in the `done_o` cycle with `seed_en_i`=1 and seed 64'h0100000000000000.
  - Required: the next cycle shows valid with 64'h0100000000000000 and `round_o`=0.
- Reset mid-run:
  - Stimulus: assert `rst` at round 10, between clock edges.
  - Required: outputs go immediately to their reset values (`const_o`=`INIT`, `const_valid_o`=0); no `done_o`; a subsequent start behaves as in the full-run scenario.
